fifo_rx_checker: RTL and testbench
==================================

Name: fifo_rx_checker

Overview:
Read-side consumer for the dual-clock FIFO test harness. It sits in the FIFO read clock domain and drains the FIFO via Empty/RdEn/Q. It checks that the received bytes follow an incrementing pattern starting at BASE. It reports pass/fail, a byte count, and the first mismatch, which the top level maps to the status LEDs.

Parameters:
DATA_W, 8, FIFO data width.
CNT_W, 11, counter width; NDATA must be at most 2^CNT_W-1.
NDATA, 18, number of bytes expected per run.
BASE, 65, expected value of byte 0; byte i must equal (BASE+i) mod 2^DATA_W.
RD_LAT, 1, number of clocks from a RdEn cycle to the matching valid Q (1..3).
TIMEOUT_CYC, 1024, length of the stall watchdog (used only with CHK_TIMEOUT_EN).

Ports:
CLOCK  in  1  FIFO read clock; all logic on its rising edge.
RESET_N  in  1  asynchronous, active-low reset.
start  in  1  single-cycle run request.
fifo_empty  in  1  FIFO Empty flag.
fifo_q  in  DATA_W  FIFO Q output.
fifo_rd_en  out  1  FIFO RdEn.
busy  out  1  high while a run is in progress.
done  out  1  high when a run finished with all NDATA bytes correct.
pass  out  1  same as done; kept as a separate LED output.
fail  out  1  high when a run ended with a mismatch or a timeout.
timeout  out  1  high when the run ended because the watchdog expired.
rx_count  out  CNT_W  number of bytes compared so far.
err_idx  out  CNT_W  index of the first mismatching byte.
err_exp  out  DATA_W  expected value at the first mismatch.
err_got  out  DATA_W  received value at the first mismatch.

Behaviour:
- Clock and reset: one clock (CLOCK). Reset is asynchronous, active-low (RESET_N).
- Reset state: all outputs are 0 and the FSM is in IDLE. fifo_rd_en drops immediately when RESET_N asserts, even mid-run.
- FSM states: IDLE, READ, DRAIN, DONE, FAIL.
- start is honoured only in IDLE, DONE or FAIL. Elsewhere it is ignored.
- On an honoured start: go to READ; clear the issue counter, the compare counter, rx_count, err_*, done, pass, fail and timeout.
- fifo_rd_en is combinational:
  - it equals READ and !fifo_empty and (iss_cnt < NDATA);
  - it is never high while fifo_empty=1 (no overread).
- Each rd_en cycle increments iss_cnt. It also pushes a token into an RD_LAT-deep valid shift register.
- A token leaving the shift register marks fifo_q as valid for that cycle. On a valid cycle:
  - compare fifo_q against (BASE+cmp_cnt) truncated to DATA_W bits, so the expected value wraps 255 to 0;
  - increment cmp_cnt and rx_count.
- Leaving READ:
  - iss_cnt reaching NDATA moves READ to DRAIN;
  - the first mismatch latches err_idx=cmp_cnt, err_exp and err_got, stops issuing (READ to DRAIN with an error flag set), and later mismatches do not overwrite the latches.
- Leaving DRAIN:
  - when no tokens are in flight and the error flag is clear: go to DONE with done=pass=1;
  - when no tokens are in flight and the error flag is set: go to FAIL with fail=1.
- busy is 1 in READ and DRAIN, otherwise 0.
- Status persistence: done, pass, fail and timeout hold until the next honoured start or reset.
- Extra FIFO contents: bytes beyond NDATA are not read and stay in the FIFO.
- NDATA=0: start goes to READ, then DRAIN, then DONE with no reads.
- Latency: with RD_LAT=1 and the FIFO never empty, done rises NDATA+2 clocks after the start cycle.

Optional Feature:
CHK_TIMEOUT_EN
- Defined:
  - a stall counter runs in READ and DRAIN and clears on every rd_en or valid cycle;
  - when it reaches TIMEOUT_CYC, stop issuing, drain the in-flight tokens, then enter FAIL with fail=timeout=1;
  - err_* keep any mismatch already latched; otherwise they stay 0.
- Undefined:
  - no stall counter is built and timeout is tied to 0;
  - a starved run stays busy indefinitely.

Test Plan:
1. Clean run, defaults: FIFO model preloaded with bytes 65..82, start pulse -> exactly 18 rd_en cycles; then done=pass=1, fail=0, rx_count=18.
2. Corruption: byte index 5 replaced with 0x00 -> fail=1, err_idx=5, err_exp=70, err_got=0, pass=0; no rd_en after the mismatch plus the in-flight drain.
3. Gappy FIFO: fifo_empty toggles every cycle -> rd_en is never high while fifo_empty=1; run still ends with pass=1 and rx_count=18.
4. Wrap: BASE=250, NDATA=10, data 250..255,0..3, RD_LAT=2 -> pass=1 and rx_count=10.
5. Reset mid-run: RESET_N pulsed low after 7 bytes -> all outputs 0 asynchronously; a fresh preload plus start then passes with rx_count=18.
6. Starvation (macro defined, TIMEOUT_CYC=16): only 4 bytes supplied -> fail=timeout=1 and rx_count=4, 16 clocks after the last valid cycle. With the macro undefined: busy stays 1 and timeout stays 0.

Source files
------------

// File: rtl/fifo_rx_checker.sv
// fifo_rx_checker: read-side consumer for the dual-clock FIFO harness.
// Drains NDATA bytes through Empty/RdEn/Q and checks them against the
// incrementing pattern BASE, BASE+1, ... (mod 2^DATA_W). It reports pass/fail,
// the byte count and the first mismatch.
// Optional macro CHK_TIMEOUT_EN builds a stall watchdog of TIMEOUT_CYC clocks
// that ends a starved run in FAIL with timeout set.
module fifo_rx_checker #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CNT_W       = 11,
    parameter int unsigned NDATA       = 18,
    parameter int unsigned BASE        = 65,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              fifo_rd_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  rx_count,
    output logic [CNT_W-1:0]  err_idx,
    output logic [DATA_W-1:0] err_exp,
    output logic [DATA_W-1:0] err_got
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0]  NDATA_C = CNT_W'(NDATA);
    localparam logic [DATA_W-1:0] BASE_C  = DATA_W'(BASE);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    iss_cnt;
    logic [CNT_W-1:0]    iss_nxt;
    logic [CNT_W-1:0]    cmp_cnt;
    logic [RD_LAT-1:0]   vld_sr;
    logic [RD_LAT-1:0]   vld_nxt;
    logic                q_valid;
    logic                mismatch;
    logic                first_err;
    logic                err_flag;
    logic                start_ok;
    logic                drained;
    logic                expire;
    logic                to_hit;
    logic [DATA_W-1:0]   exp_byte;

    assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));
    assign busy       = (state == S_READ) || (state == S_DRAIN);
    assign fifo_rd_en = (state == S_READ) && !fifo_empty && (iss_cnt < NDATA_C);
    assign iss_nxt    = iss_cnt + CNT_W'(fifo_rd_en);
    assign q_valid    = vld_sr[RD_LAT-1];
    assign exp_byte   = BASE_C + DATA_W'(cmp_cnt);
    assign mismatch   = q_valid && (fifo_q != exp_byte);
    assign first_err  = mismatch && !err_flag;
    assign drained    = (vld_nxt == '0);
    assign rx_count   = cmp_cnt;
    assign pass       = done;

    // Valid-token pipeline: a RdEn enters at bit 0 and marks Q valid RD_LAT clocks later.
    always_comb begin
        vld_nxt    = vld_sr << 1;
        vld_nxt[0] = fifo_rd_en;
    end

`ifdef CHK_TIMEOUT_EN
    localparam int unsigned         STALL_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [STALL_W-1:0]  STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               to_flag;

    // The clock in which the counter would reach TIMEOUT_CYC is the expiry clock,
    // so FAIL is registered exactly TIMEOUT_CYC clocks after the last activity.
    assign expire = busy && !fifo_rd_en && !q_valid && (stall_cnt == STALL_LAST);
    assign to_hit = to_flag || expire;

    // Stall watchdog: counts idle clocks while busy, cleared by any read or compare.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cnt <= '0;
        end else if (!busy || start_ok || fifo_rd_en || q_valid || expire) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Timeout flags: remembered through the drain, reported on entry to FAIL.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            to_flag <= 1'b0;
            timeout <= 1'b0;
        end else if (start_ok) begin
            to_flag <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (expire) begin
                to_flag <= 1'b1;
            end
            if ((state != S_FAIL) && (state_nxt == S_FAIL) && to_hit) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign expire             = 1'b0;
    assign to_hit             = 1'b0;
    assign timeout            = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Exit decisions use this clock's compare result and the
    // post-shift token pipeline so a run ends without an extra idle clock.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start_ok) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (first_err) begin
                    state_nxt = S_DRAIN;
                end else if (expire) begin
                    state_nxt = drained ? S_FAIL : S_DRAIN;
                end else if (iss_nxt >= NDATA_C) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drained) begin
                    state_nxt = (err_flag || first_err || to_hit) ? S_FAIL : S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: issue/compare counters, token pipeline, first-error latch, status.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            iss_cnt  <= '0;
            cmp_cnt  <= '0;
            vld_sr   <= '0;
            err_flag <= 1'b0;
            err_idx  <= '0;
            err_exp  <= '0;
            err_got  <= '0;
            done     <= 1'b0;
            fail     <= 1'b0;
        end else if (start_ok) begin
            iss_cnt  <= '0;
            cmp_cnt  <= '0;
            vld_sr   <= '0;
            err_flag <= 1'b0;
            err_idx  <= '0;
            err_exp  <= '0;
            err_got  <= '0;
            done     <= 1'b0;
            fail     <= 1'b0;
        end else begin
            vld_sr  <= vld_nxt;
            iss_cnt <= iss_nxt;
            if (q_valid) begin
                cmp_cnt <= cmp_cnt + 1'b1;
            end
            if (first_err) begin
                err_flag <= 1'b1;
                err_idx  <= cmp_cnt;
                err_exp  <= exp_byte;
                err_got  <= fifo_q;
            end
            if ((state == S_DRAIN) && (state_nxt == S_DONE)) begin
                done <= 1'b1;
            end
            if ((state != S_FAIL) && (state_nxt == S_FAIL)) begin
                fail <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rx_checker.sv
// tb_fifo_rx_checker: directed checks of fifo_rx_checker against small FIFO models.
// dut_a: defaults (RD_LAT=1, NDATA=18, BASE=65) with TIMEOUT_CYC=16.
// dut_b: BASE=250, NDATA=10, RD_LAT=2 (pattern wraps 255 -> 0).
// dut_c: NDATA=0.
module tb_fifo_rx_checker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // ---------------- DUT A ----------------
    logic        start_a, empty_a, rd_en_a, busy_a, done_a, pass_a, fail_a, to_a;
    logic [7:0]  q_a, ee_a, eg_a;
    logic [10:0] rx_a, ei_a;
    logic [7:0]  mem_a [0:63];
    int unsigned wr_a, rd_a, rdcnt_a, overrd_a;
    logic        clr_a, gappy_a, gap_a;

    fifo_rx_checker #(.TIMEOUT_CYC(16)) dut_a (
        .CLOCK(clk), .RESET_N(rst_n), .start(start_a), .fifo_empty(empty_a),
        .fifo_q(q_a), .fifo_rd_en(rd_en_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .fail(fail_a), .timeout(to_a), .rx_count(rx_a),
        .err_idx(ei_a), .err_exp(ee_a), .err_got(eg_a)
    );

    assign empty_a = (rd_a >= wr_a) || gap_a;

    always @(posedge clk) begin
        if (clr_a) begin
            rd_a  <= 0;
            gap_a <= 1'b0;
        end else begin
            if (rd_en_a) begin
                q_a  <= mem_a[rd_a[5:0]];
                rd_a <= rd_a + 1;
            end
            gap_a <= gappy_a & ~gap_a;
        end
    end

    always @(negedge clk) begin
        if (rd_en_a) begin
            rdcnt_a <= rdcnt_a + 1;
            if (empty_a) overrd_a <= overrd_a + 1;
        end
    end

    // ---------------- DUT B ----------------
    logic        start_b, empty_b, rd_en_b, busy_b, done_b, pass_b, fail_b, to_b;
    logic [7:0]  q_b, s1_b, ee_b, eg_b;
    logic [10:0] rx_b, ei_b;
    logic [7:0]  mem_b [0:63];
    int unsigned wr_b, rd_b, rdcnt_b;
    logic        clr_b;

    fifo_rx_checker #(.BASE(250), .NDATA(10), .RD_LAT(2)) dut_b (
        .CLOCK(clk), .RESET_N(rst_n), .start(start_b), .fifo_empty(empty_b),
        .fifo_q(q_b), .fifo_rd_en(rd_en_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .fail(fail_b), .timeout(to_b), .rx_count(rx_b),
        .err_idx(ei_b), .err_exp(ee_b), .err_got(eg_b)
    );

    assign empty_b = (rd_b >= wr_b);

    always @(posedge clk) begin
        if (clr_b) begin
            rd_b <= 0;
        end else begin
            if (rd_en_b) begin
                s1_b <= mem_b[rd_b[5:0]];
                rd_b <= rd_b + 1;
            end
            q_b <= s1_b;
        end
    end

    always @(negedge clk) if (rd_en_b) rdcnt_b <= rdcnt_b + 1;

    // ---------------- DUT C ----------------
    logic        start_c, rd_en_c, busy_c, done_c, pass_c, fail_c, to_c;
    logic [7:0]  ee_c, eg_c;
    logic [10:0] rx_c, ei_c;
    int unsigned rdcnt_c;

    fifo_rx_checker #(.NDATA(0)) dut_c (
        .CLOCK(clk), .RESET_N(rst_n), .start(start_c), .fifo_empty(1'b0),
        .fifo_q(8'h00), .fifo_rd_en(rd_en_c), .busy(busy_c), .done(done_c),
        .pass(pass_c), .fail(fail_c), .timeout(to_c), .rx_count(rx_c),
        .err_idx(ei_c), .err_exp(ee_c), .err_got(eg_c)
    );

    always @(negedge clk) if (rd_en_c) rdcnt_c <= rdcnt_c + 1;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic preload_a(input int unsigned n, input int unsigned bad_idx,
                             input logic [7:0] bad_val, input logic use_bad);
        for (int unsigned i = 0; i < n; i++) mem_a[i[5:0]] = 8'(65 + i);
        if (use_bad) mem_a[bad_idx[5:0]] = bad_val;
        wr_a  = n;
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
    endtask

    task automatic preload_b(input int unsigned n, input int unsigned bad_idx,
                             input logic [7:0] bad_val, input logic use_bad);
        for (int unsigned i = 0; i < n; i++) mem_b[i[5:0]] = 8'(250 + i);
        if (use_bad) mem_b[bad_idx[5:0]] = bad_val;
        wr_b  = n;
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
    endtask

    typedef struct {
        int unsigned n_supply;
        logic        use_bad;
        int unsigned bad_idx;
        logic [7:0]  bad_val;
        logic        gappy;
        int unsigned restart_at;
        logic        exp_pass;
        int unsigned exp_rx;
        int unsigned exp_ei;
        logic [7:0]  exp_ee;
        logic [7:0]  exp_eg;
        int unsigned exp_rd;
        int unsigned exp_left;
        int unsigned exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic run_a(input vec_t v);
        int unsigned rd0;
        int unsigned lat;
        preload_a(v.n_supply, v.bad_idx, v.bad_val, v.use_bad);
        gappy_a = v.gappy;
        rd0 = rdcnt_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("a_busy_on_start", 32'(busy_a), 32'd1);
        chk("a_status_cleared", 32'({done_a, pass_a, fail_a, to_a}), 32'd0);
        chk("a_rx_cleared", 32'(rx_a), 32'd0);
        lat = 1;
        while (!(done_a || fail_a) && lat < 300) begin
            @(negedge clk);
            lat++;
            start_a = (lat == v.restart_at);
        end
        start_a = 1'b0;
        chk("a_run_ends", 32'(done_a || fail_a), 32'd1);
        if (v.exp_lat != 0) chk("a_done_latency", lat, v.exp_lat);
        repeat (3) @(negedge clk);
        chk("a_done", 32'(done_a), 32'(v.exp_pass));
        chk("a_pass", 32'(pass_a), 32'(v.exp_pass));
        chk("a_fail", 32'(fail_a), 32'(!v.exp_pass));
        chk("a_timeout", 32'(to_a), 32'd0);
        chk("a_busy_idle", 32'(busy_a), 32'd0);
        chk("a_rx_count", 32'(rx_a), v.exp_rx);
        chk("a_err_idx", 32'(ei_a), v.exp_ei);
        chk("a_err_exp", 32'(ee_a), 32'(v.exp_ee));
        chk("a_err_got", 32'(eg_a), 32'(v.exp_eg));
        chk("a_rd_en_cycles", rdcnt_a - rd0, v.exp_rd);
        chk("a_left_in_fifo", wr_a - rd_a, v.exp_left);
        gappy_a = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned cnt;
        int unsigned rd0;

        //            supply bad idx  val    gap rst  pass rx  ei  ee     eg      rd  left lat
        vecs[0] = '{18, 1'b0, 0,  8'h00, 1'b0, 0, 1'b1, 18, 0,  8'd0,  8'd0,   18, 0,  20};
        vecs[1] = '{18, 1'b1, 5,  8'h00, 1'b0, 0, 1'b0, 7,  5,  8'd70, 8'd0,   7,  11, 0};
        vecs[2] = '{18, 1'b0, 0,  8'h00, 1'b1, 0, 1'b1, 18, 0,  8'd0,  8'd0,   18, 0,  0};
        vecs[3] = '{18, 1'b1, 0,  8'hFF, 1'b0, 0, 1'b0, 2,  0,  8'd65, 8'd255, 2,  16, 0};
        vecs[4] = '{18, 1'b1, 17, 8'h00, 1'b0, 0, 1'b0, 18, 17, 8'd82, 8'd0,   18, 0,  0};
        vecs[5] = '{25, 1'b0, 0,  8'h00, 1'b0, 0, 1'b1, 18, 0,  8'd0,  8'd0,   18, 7,  20};
        vecs[6] = '{18, 1'b0, 0,  8'h00, 1'b0, 5, 1'b1, 18, 0,  8'd0,  8'd0,   18, 0,  20};

        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        gappy_a = 1'b0; clr_a = 1'b1; clr_b = 1'b1;
        wr_a = 0; wr_b = 0; rdcnt_a = 0; rdcnt_b = 0; rdcnt_c = 0; overrd_a = 0;
        #12;
        chk("reset_outputs_a", 32'({rd_en_a, busy_a, done_a, pass_a, fail_a, to_a}), 32'd0);
        chk("reset_counts_a", 32'({rx_a, ei_a}), 32'd0);
        chk("reset_err_a", 32'({ee_a, eg_a}), 32'd0);
        chk("reset_outputs_b", 32'({rd_en_b, busy_b, done_b, fail_b, rx_b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0;
        @(negedge clk);

        // Table of full runs on dut_a.
        for (int v = 0; v < 7; v++) run_a(vecs[v]);
        chk("a_no_overread", overrd_a, 32'd0);

        // Wrap-around runs on dut_b: clean, then corrupt byte 6 (expected 0).
        for (int k = 0; k < 2; k++) begin
            preload_b(10, 6, 8'd1, (k == 1));
            rd0 = rdcnt_b;
            start_b = 1'b1;
            @(negedge clk);
            start_b = 1'b0;
            cnt = 0;
            while (!(done_b || fail_b) && cnt < 200) begin @(negedge clk); cnt++; end
            chk("b_run_ends", 32'(done_b || fail_b), 32'd1);
            if (k == 0) begin
                chk("b_pass", 32'({pass_b, done_b, fail_b}), 32'b110);
                chk("b_rx_count", 32'(rx_b), 32'd10);
                chk("b_rd_en_cycles", rdcnt_b - rd0, 32'd10);
            end else begin
                chk("b_fail", 32'({pass_b, done_b, fail_b}), 32'b001);
                chk("b_err_idx", 32'(ei_b), 32'd6);
                chk("b_err_exp", 32'(ee_b), 32'd0);
                chk("b_err_got", 32'(eg_b), 32'd1);
                chk("b_rx_count", 32'(rx_b), 32'd9);
                chk("b_rd_en_cycles", rdcnt_b - rd0, 32'd9);
            end
            chk("b_timeout", 32'(to_b), 32'd0);
        end

        // NDATA=0: READ, DRAIN, then DONE with no reads.
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        chk("c_busy_read", 32'({busy_c, done_c}), 32'b10);
        @(negedge clk);
        chk("c_busy_drain", 32'({busy_c, done_c}), 32'b10);
        @(negedge clk);
        chk("c_done", 32'({busy_c, done_c, pass_c, fail_c, to_c}), 32'b01100);
        chk("c_no_reads", rdcnt_c, 32'd0);
        chk("c_counts", 32'({rx_c, ei_c, ee_c, eg_c}), 32'd0);

        // Asynchronous reset in the middle of a run.
        preload_a(18, 0, 8'h00, 1'b0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cnt = 0;
        while (rx_a != 11'd7 && cnt < 100) begin @(negedge clk); cnt++; end
        chk("a_reach_7_bytes", 32'(rx_a), 32'd7);
        chk("a_rd_en_before_reset", 32'(rd_en_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("a_async_rd_en", 32'(rd_en_a), 32'd0);
        chk("a_async_status", 32'({busy_a, done_a, pass_a, fail_a, to_a}), 32'd0);
        chk("a_async_counts", 32'({rx_a, ei_a}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_a(vecs[0]);

        // Starvation: only 4 bytes ever arrive.
        preload_a(4, 0, 8'h00, 1'b0);
        rd0 = rdcnt_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cnt = 0;
        while (rx_a != 11'd4 && cnt < 100) begin @(negedge clk); cnt++; end
        chk("starve_rx_4", 32'(rx_a), 32'd4);
`ifdef CHK_TIMEOUT_EN
        cnt = 0;
        while (!fail_a && cnt < 100) begin @(negedge clk); cnt++; end
        chk("starve_timeout_delay", cnt, 32'd16);
        chk("starve_status", 32'({busy_a, done_a, pass_a, fail_a, to_a}), 32'b00011);
        chk("starve_rx_count", 32'(rx_a), 32'd4);
        chk("starve_err_clear", 32'({ei_a, ee_a, eg_a}), 32'd0);
`else
        repeat (60) @(negedge clk);
        chk("starve_busy", 32'(busy_a), 32'd1);
        chk("starve_no_timeout", 32'({to_a, fail_a, done_a}), 32'd0);
        chk("starve_rx_count", 32'(rx_a), 32'd4);
`endif
        chk("starve_rd_en_cycles", rdcnt_a - rd0, 32'd4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
